// File: rtl/leb128_pkg.sv
// Shared LEB128 constants, length helper and encoder state type.
// Used by the stream encoder and by the decoder-side benches.
package leb128_pkg;

    localparam int LEB128_PAYLOAD_W = 7;
    localparam int LEB128_CONT_BIT  = 7;

    function automatic int leb128_maxlen(input int w);
        return (w + LEB128_PAYLOAD_W - 1) / LEB128_PAYLOAD_W;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } leb128_enc_state_t;

endpackage

// File: rtl/pack_i64_stream_if.sv
// Value-in / byte-out handshake bundle of the LEB128 stream encoder.
// o_len exists only when LEB128_LEN_EN is defined.
interface pack_i64_stream_if #(
    parameter int W = 64
);
    logic [W-1:0] i_data;
    logic         i_valid;
    logic         i_ready;
    logic [7:0]   o_byte;
    logic         o_valid;
    logic         o_ready;
    logic         o_last;
`ifdef LEB128_LEN_EN
    logic [3:0]   o_len;

    modport slave (
        input  i_data, i_valid, o_ready,
        output i_ready, o_byte, o_valid, o_last, o_len
    );
    modport master (
        output i_data, i_valid, o_ready,
        input  i_ready, o_byte, o_valid, o_last, o_len
    );
`else
    modport slave (
        input  i_data, i_valid, o_ready,
        output i_ready, o_byte, o_valid, o_last
    );
    modport master (
        output i_data, i_valid, o_ready,
        input  i_ready, o_byte, o_valid, o_last
    );
`endif
endinterface

// File: rtl/leb128_len.sv
// Purpose: combinational byte count of the (S/U)LEB128 encoding of a W-bit value.
// Latency: 0 cycles, pure combinational.
// Backpressure: none, no handshake.
module leb128_len
    import leb128_pkg::*;
#(
    parameter int W      = 64,
    parameter int SIGNED = 1
) (
    input  logic [W-1:0] value,
    output logic [3:0]   len
);
    localparam int MAXLEN = leb128_maxlen(W);

    // A value fits in n bytes when everything above the n*7 payload bits is
    // pure sign (signed) or zero (unsigned) extension.
    function automatic logic fits(input logic [W-1:0] v, input int n);
        logic [W-1:0] t;
        t = '0;
        if (SIGNED != 0) begin
            t = $signed(v) >>> (LEB128_PAYLOAD_W * n - 1);
            return (t == '0) || (t == '1);
        end
        t = v >> (LEB128_PAYLOAD_W * n);
        return t == '0;
    endfunction

    always_comb begin
        len = 4'(MAXLEN);
        for (int n = MAXLEN - 1; n >= 1; n--) begin
            if (fits(value, n)) len = 4'(n);
        end
    end

endmodule

// File: rtl/pack_i64_stream.sv
// Purpose: streaming (S/U)LEB128 encoder, one W-bit value in, one byte per cycle out; LEB128_LEN_EN adds o_len.
// Latency: first byte valid 1 cycle after accept; back-to-back values with no bubble.
// Backpressure: o_ready low holds o_byte/o_last/shift state; i_ready only on IDLE or final-byte handshake.
module pack_i64_stream
    import leb128_pkg::*;
#(
    parameter int W      = 64,
    parameter int SIGNED = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    pack_i64_stream_if.slave     bus
);
    localparam int         MAXLEN   = leb128_maxlen(W);
    localparam logic [3:0] LAST_IDX = 4'(MAXLEN - 1);

    leb128_enc_state_t state, state_nxt;
    logic [W-1:0]      sh, sh_nxt, sh_shift;
    logic [3:0]        cnt, cnt_nxt;
    logic              fin_raw, fin, load;
    logic              i_ready, o_valid, o_last;
    logic [7:0]        o_byte;

    generate
        if (SIGNED != 0) begin : g_signed
            assign fin_raw  = (&sh[W-1:LEB128_PAYLOAD_W-1]) | ~(|sh[W-1:LEB128_PAYLOAD_W-1]);
            assign sh_shift = $signed(sh) >>> LEB128_PAYLOAD_W;
        end else begin : g_unsigned
            assign fin_raw  = ~(|sh[W-1:LEB128_PAYLOAD_W]);
            assign sh_shift = sh >> LEB128_PAYLOAD_W;
        end
    endgenerate

    // The count bound is redundant with full extension, but pins termination
    // even if the shift state were ever corrupted.
    assign fin = fin_raw | (cnt == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sh    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sh    <= sh_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sh_nxt    = sh;
        cnt_nxt   = cnt;
        load      = 1'b0;
        i_ready   = 1'b0;
        o_valid   = 1'b0;
        o_byte    = 8'h00;
        o_last    = 1'b0;
        case (state)
            IDLE: begin
                i_ready = 1'b1;
                if (bus.i_valid) begin
                    load      = 1'b1;
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                o_valid = 1'b1;
                o_byte  = {~fin, sh[LEB128_PAYLOAD_W-1:0]};
                o_last  = fin;
                if (bus.o_ready) begin
                    if (!fin) begin
                        sh_nxt  = sh_shift;
                        cnt_nxt = cnt + 4'd1;
                    end else begin
                        i_ready = 1'b1;
                        if (bus.i_valid) load = 1'b1;
                        else             state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (load) begin
            sh_nxt  = bus.i_data;
            cnt_nxt = '0;
        end
    end

    assign bus.i_ready = i_ready;
    assign bus.o_valid = o_valid;
    assign bus.o_byte  = o_byte;
    assign bus.o_last  = o_last;

`ifdef LEB128_LEN_EN
    logic [3:0] len_calc;
    logic [3:0] len_q;

    leb128_len #(.W(W), .SIGNED(SIGNED)) u_len (
        .value (bus.i_data),
        .len   (len_calc)
    );

    always_ff @(posedge clk) begin
        if (rst)       len_q <= '0;
        else if (load) len_q <= len_calc;
    end

    assign bus.o_len = len_q;
`endif

endmodule

// File: tb/tb_pack_i64_stream.sv
// Bench for pack_i64_stream: signed and unsigned instances, directed byte lists
// plus random values checked against a plain LEB128 reference model.
module tb_pack_i64_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        d_valid = 1'b0;
    logic        d_ordy  = 1'b0;
    logic [63:0] d_data  = '0;
    bit          sel = 1'b0;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    pack_i64_stream_if #(.W(64)) bs ();
    pack_i64_stream_if #(.W(64)) bu ();

    assign bs.i_valid = d_valid;
    assign bs.i_data  = d_data;
    assign bs.o_ready = d_ordy;
    assign bu.i_valid = d_valid;
    assign bu.i_data  = d_data;
    assign bu.o_ready = d_ordy;

    pack_i64_stream #(.W(64), .SIGNED(1)) dut_s (.clk(clk), .rst(rst), .bus(bs.slave));
    pack_i64_stream #(.W(64), .SIGNED(0)) dut_u (.clk(clk), .rst(rst), .bus(bu.slave));

    logic [7:0] s_byte;
    logic       s_valid, s_last, s_irdy;
    assign s_byte  = sel ? bu.o_byte  : bs.o_byte;
    assign s_valid = sel ? bu.o_valid : bs.o_valid;
    assign s_last  = sel ? bu.o_last  : bs.o_last;
    assign s_irdy  = sel ? bu.i_ready : bs.i_ready;
`ifdef LEB128_LEN_EN
    logic [3:0] s_len;
    assign s_len = sel ? bu.o_len : bs.o_len;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference encoder: textbook LEB128 loop on a 64-bit integer.
    function automatic void build_exp(input bit uns, input logic [63:0] v);
        longint     s;
        logic [63:0] u;
        logic [6:0] b;
        bit         done;
        exp_q.delete();
        s = longint'(v);
        u = v;
        for (int k = 0; k < 12; k++) begin
            if (uns) begin
                b    = u[6:0];
                u    = u >> 7;
                done = (u == 64'd0);
            end else begin
                b    = s[6:0];
                s    = s >>> 7;
                done = (s == 0 && !b[6]) || (s == -1 && b[6]);
            end
            exp_q.push_back({~done, b});
            if (done) break;
        end
    endfunction

    // Send v, then drain its bytes against exp_q with stall_pct% o_ready stalls.
    task automatic run(input logic [63:0] v, input int stall_pct, input string tag);
        int idx;
        int cyc;
        bit last;
        @(posedge clk); #1;
        d_valid = 1'b1; d_data = v; d_ordy = 1'b0;
        @(negedge clk);
        check({tag, "/accept_rdy"}, 64'(s_irdy), 64'd1);
        @(posedge clk); #1;
        d_valid = 1'b0; d_data = {$urandom, $urandom};
        idx = 0; cyc = 0;
        while (idx < exp_q.size() && cyc < 400) begin
            d_ordy = ($urandom_range(99) >= 32'(stall_pct));
            last = (idx == exp_q.size() - 1);
            @(negedge clk);
            check({tag, "/valid"}, 64'(s_valid), 64'd1);
            check({tag, "/byte"},  64'(s_byte),  64'(exp_q[idx]));
            check({tag, "/last"},  64'(s_last),  64'(last));
            check({tag, "/irdy"},  64'(s_irdy),  64'(d_ordy && last));
`ifdef LEB128_LEN_EN
            check({tag, "/len"},   64'(s_len),   64'(exp_q.size()));
`endif
            if (d_ordy) idx++;
            cyc++;
            @(posedge clk); #1;
        end
        check({tag, "/drained"}, 64'(idx), 64'(exp_q.size()));
        d_ordy = 1'b0;
        @(negedge clk);
        check({tag, "/idle_valid"}, 64'(s_valid), 64'd0);
        check({tag, "/idle_rdy"},   64'(s_irdy),  64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] v;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst/valid", 64'(s_valid), 64'd0);
        check("rst/irdy",  64'(s_irdy),  64'd1);
        check("rst/last",  64'(s_last),  64'd0);
        check("rst/byte",  64'(s_byte),  64'h00);
`ifdef LEB128_LEN_EN
        check("rst/len",   64'(s_len),   64'd0);
`endif
        @(posedge clk); #1; rst = 1'b0;

        // Single-byte values
        exp_q = '{8'h00}; run(64'd0, 0, "zero");
        exp_q = '{8'h7F}; run(-64'sd1, 0, "m1");
        exp_q = '{8'h3F}; run(64'd63, 0, "p63");
        exp_q = '{8'h40}; run(-64'sd64, 0, "m64");

        // Sign boundaries and multi-byte
        exp_q = '{8'hC0, 8'h00};         run(64'd64, 0, "p64");
        exp_q = '{8'hBF, 8'h7F};         run(-64'sd65, 0, "m65");
        exp_q = '{8'hE5, 8'h8E, 8'h26};  run(64'd624485, 0, "p624485");
        exp_q = '{8'hC0, 8'hBB, 8'h78};  run(-64'sd123456, 0, "m123456");

        // Extremes: ten bytes each
        exp_q.delete(); repeat (9) exp_q.push_back(8'h80); exp_q.push_back(8'h7F);
        run(64'h8000_0000_0000_0000, 0, "min");
        exp_q.delete(); repeat (9) exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
        run(64'h7FFF_FFFF_FFFF_FFFF, 0, "max");

        // Backpressure
        exp_q = '{8'hE5, 8'h8E, 8'h26};  run(64'd624485, 60, "bp624485");

        // Back-to-back 1 then 2
        @(posedge clk); #1; d_valid = 1'b1; d_data = 64'd1; d_ordy = 1'b1;
        @(negedge clk); check("b2b/rdy0", 64'(s_irdy), 64'd1);
        @(posedge clk); #1; d_data = 64'd2;
        @(negedge clk);
        check("b2b/byte1", 64'(s_byte), 64'h01);
        check("b2b/last1", 64'(s_last), 64'd1);
        check("b2b/rdy1",  64'(s_irdy), 64'd1);
        @(posedge clk); #1; d_valid = 1'b0; d_data = 64'd99;
        @(negedge clk);
        check("b2b/valid2", 64'(s_valid), 64'd1);
        check("b2b/byte2",  64'(s_byte),  64'h02);
        @(posedge clk); #1; d_ordy = 1'b0;
        @(negedge clk); check("b2b/idle", 64'(s_valid), 64'd0);

        // Reset mid-value
        @(posedge clk); #1; d_valid = 1'b1; d_data = -64'sd123456; d_ordy = 1'b1;
        @(posedge clk); #1; d_valid = 1'b0;
        @(negedge clk); check("mrst/byte0", 64'(s_byte), 64'hC0);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0; d_ordy = 1'b0;
        @(negedge clk);
        check("mrst/valid", 64'(s_valid), 64'd0);
        check("mrst/irdy",  64'(s_irdy),  64'd1);
        exp_q = '{8'h05}; run(64'd5, 0, "after_rst");

        // Random signed values against the reference model
        for (int k = 0; k < 25; k++) begin
            v = {$urandom, $urandom};
            v = $signed(v) >>> $urandom_range(63);
            build_exp(1'b0, v);
            run(v, 30, "rnd_s");
        end

        // Unsigned instance: both DUTs restart from reset
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0; sel = 1'b1;
        exp_q = '{8'h80, 8'h01}; run(64'd128, 0, "u128");
        exp_q = '{8'h7F};        run(64'd127, 0, "u127");
        for (int k = 0; k < 15; k++) begin
            v = {$urandom, $urandom};
            v = v >> $urandom_range(63);
            build_exp(1'b1, v);
            run(v, 30, "rnd_u");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pack_i64_stream.md
Name: pack_i64_stream

Overview:
- Streaming signed-LEB128 encoder, the transmit-side counterpart of the combinational i64 unpacker.
- Accepts one W-bit two's-complement integer per transaction on a valid/ready input.
- Emits the LEB128 byte sequence one byte per cycle on a valid/ready byte stream, with an end-of-value marker.
- Sits between the value producer and the byte serializer/packer.

Parameters:
- W, 64, input integer width in bits (legal range 8..64)
- SIGNED, 1, 1 = SLEB128 (arithmetic shift, sign-aware termination); 0 = ULEB128 (logical shift)
- MAXLEN, derived = ceil(W/7), maximum bytes per value (10 for W=64)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- i_data  in  W  value to encode
- i_valid  in  1  i_data is valid
- i_ready  out  1  encoder accepts i_data this cycle
- o_byte  out  8  encoded byte; bit7 = continuation, bits6:0 = payload
- o_valid  out  1  o_byte is valid
- o_ready  in  1  sink accepts o_byte this cycle
- o_last  out  1  o_byte is the final byte of the value (bit7 of o_byte = 0)
- o_len  out  4  total byte count of the current value (only with LEB128_LEN_EN)

Behaviour:
- Reset: state=IDLE, shift register sh=0, byte counter cnt=0, o_valid=0, i_ready=1, o_last=0, o_byte=0x00.
- Reset mid-value discards the value and its remaining bytes; the next cycle is IDLE.
- FSM has two states, IDLE and EMIT.
- IDLE:
  - i_ready=1 and o_valid=0.
  - On i_valid: sh<=i_data, cnt<=0, go to EMIT.
  - Latency from accept to first o_valid is 1 cycle.
- EMIT:
  - o_valid=1.
  - o_byte={~fin, sh[6:0]} and o_last=fin; both are combinational from sh.
  - fin when SIGNED=1: sh[W-1:6] is all-zeros or all-ones.
  - fin when SIGNED=0: sh[W-1:7]==0.
- On an o_valid&&o_ready handshake with fin=0:
  - SIGNED=1: sh<=sh>>>7 (arithmetic shift).
  - SIGNED=0: sh<=sh>>7 (logical shift).
  - cnt<=cnt+1.
- On an o_valid&&o_ready handshake with fin=1:
  - i_ready=1 in that same cycle (back-to-back throughput).
  - If i_valid: load the new value, stay in EMIT, cnt<=0.
  - Otherwise go to IDLE.
- i_ready=0 in EMIT except on the final-byte handshake cycle.
- Backpressure: while o_valid && !o_ready, o_byte, o_last and sh hold stable.
- Termination guarantee: fin is always true at cnt==MAXLEN-1, because sh is then fully sign/zero extended. cnt never exceeds MAXLEN-1.
- Byte count is 1 for 0 and -1, and 10 for INT64_MIN and INT64_MAX at W=64.
- i_data is sampled only on the accept cycle; later changes have no effect.

Optional Feature:
- Macro: LEB128_LEN_EN.
- Defined:
  - At accept, a combinational length calculator computes the total byte count from i_data and registers it into o_len.
  - o_len is valid and stable for every byte of the value and resets to 0.
- Undefined:
  - Port o_len and the calculator are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package leb128_pkg holds:
  - constants LEB128_PAYLOAD_W=7 and LEB128_CONT_BIT=7
  - function leb128_maxlen(W)
  - enum type leb128_enc_state_t {IDLE, EMIT}
- Package items are reused by the decoder-side benches.
- One sub-module, leb128_len: combinational W-bit to 4-bit byte-count calculator, parameterised by W and SIGNED. It is instantiated only under LEB128_LEN_EN and is reusable by the decoder bench as a reference model.

Test Plan:
- Single-byte values, o_ready=1 (0, -1, 63, -64) -> 0x00, 0x7F, 0x3F, 0x40, each with o_last=1; o_len=1 when enabled.
- Sign-boundary values: 64 -> C0 00; -65 -> BF 7F; 624485 -> E5 8E 26; -123456 -> C0 BB 78; o_last asserted only on the final byte.
- INT64_MIN -> 80×9 then 7F. INT64_MAX -> FF×9 then 00. Both are 10 bytes, cnt reaches 9, o_len=10.
- Random o_ready backpressure on 624485 -> byte stream identical, o_byte stable while stalled, i_ready low until the final handshake.
- Back-to-back i_valid with values 1 then 2 -> 01, 02 on consecutive cycles with no bubble; i_ready high on the final-byte cycle.
- rst asserted after the first byte of -123456 -> next cycle o_valid=0, i_ready=1. A following value of 5 encodes as 05. SIGNED=0 variant: 128 -> 80 01.
